// File: rtl/pipe_hazard_tracker.sv
// pipe_hazard_tracker: forwarding, load-use stall and branch flush control for an in-order pipeline
// Ports: clk/reset (async, active-low); ValidD, Rs1D, Rs2D, RdD, RegWriteD, IsLoadD describe the D instruction;
//   PCSrcE is a taken branch resolved in E; StallF/StallD/FlushD/FlushE drive the F/D/E pipeline registers;
//   FwdAE/FwdBE select the E operand source (0 = register file, k = result of stage k);
//   StallCnt/FlushCnt are performance counters, present only when HAZARD_PERF_EN is defined (else tied to 0).
module pipe_hazard_tracker #(
  parameter int DEPTH          = 3,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int LOAD_READY     = 2,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ValidD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic                      RegWriteD,
  input  logic                      IsLoadD,
  input  logic                      PCSrcE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic [$clog2(DEPTH)-1:0]  FwdAE,
  output logic [$clog2(DEPTH)-1:0]  FwdBE,
  output logic [CNT_WIDTH-1:0]      StallCnt,
  output logic [CNT_WIDTH-1:0]      FlushCnt
);
  localparam int FW = $clog2(DEPTH);
  localparam int AW = REG_ADDR_WIDTH;
  logic [DEPTH-1:0] v_q, v_d, we_q, we_d, ld_q, ld_d, wr;
  logic [DEPTH-1:0][AW-1:0] rd_q, rd_d;
  logic [AW-1:0] rs1e_q, rs1e_d, rs2e_q, rs2e_d;
  logic lu, issue;
  always_comb begin
    for (int k = 0; k < DEPTH; k++) wr[k] = v_q[k] && we_q[k] && (rd_q[k] != '0);
  end
  // a load younger than LOAD_READY-1 cannot yet feed a consumer entering E next cycle
  always_comb begin
    lu = 1'b0;
    for (int j = 0; j < LOAD_READY - 1; j++)
      lu = lu || (wr[j] && ld_q[j] && (rd_q[j] == Rs1D || rd_q[j] == Rs2D));
    lu = lu && ValidD;
  end
  // scan oldest to youngest so the youngest match wins; a too-young load match forces 0
  always_comb begin
    FwdAE = '0;
    FwdBE = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (wr[k] && rd_q[k] == rs1e_q) FwdAE = (ld_q[k] && k < LOAD_READY) ? '0 : FW'(k);
      if (wr[k] && rd_q[k] == rs2e_q) FwdBE = (ld_q[k] && k < LOAD_READY) ? '0 : FW'(k);
    end
    if (!v_q[0]) begin
      FwdAE = '0;
      FwdBE = '0;
    end
  end
  // a taken branch makes D wrong-path, so the flush overrides the stall
  assign StallF = lu && !PCSrcE;
  assign StallD = StallF;
  assign FlushD = PCSrcE;
  assign FlushE = PCSrcE || lu;
  assign issue  = ValidD && !FlushE;
  always_comb begin
    v_d    = {v_q[DEPTH-2:0], issue};
    we_d   = {we_q[DEPTH-2:0], issue && RegWriteD};
    ld_d   = {ld_q[DEPTH-2:0], issue && IsLoadD};
    rd_d   = {rd_q[DEPTH-2:0], (issue ? RdD : {AW{1'b0}})};
    rs1e_d = issue ? Rs1D : '0;
    rs2e_d = issue ? Rs2D : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q    <= '0;
      we_q   <= '0;
      ld_q   <= '0;
      rd_q   <= '0;
      rs1e_q <= '0;
      rs2e_q <= '0;
    end else begin
      v_q    <= v_d;
      we_q   <= we_d;
      ld_q   <= ld_d;
      rd_q   <= rd_d;
      rs1e_q <= rs1e_d;
      rs2e_q <= rs2e_d;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + CNT_WIDTH'(StallD);
    flush_cnt_d = flush_cnt_q + CNT_WIDTH'(FlushD);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
`else
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// tb_pipe_hazard_tracker: scoreboard bench with an issue-timestamp reference model
module tb_pipe_hazard_tracker;
  localparam int DEPTH = 5;
  localparam int AW = 5;
  localparam int LR = 3;
  localparam int CW = 8;
  localparam int FW = $clog2(DEPTH);
  typedef struct { logic [AW-1:0] rd, rs1, rs2; logic we, ld; int birth; } ins_t;
  typedef struct { logic sf, sd, fd, fe; logic [FW-1:0] fa, fb; logic [CW-1:0] sc, fc; } exp_t;
  logic clk = 1'b0, reset = 1'b0;
  logic ValidD = 1'b0, RegWriteD = 1'b0, IsLoadD = 1'b0, PCSrcE = 1'b0;
  logic [AW-1:0] Rs1D = '0, Rs2D = '0, RdD = '0;
  logic StallF, StallD, FlushD, FlushE;
  logic [FW-1:0] FwdAE, FwdBE;
  logic [CW-1:0] StallCnt, FlushCnt;
  ins_t fl[$];
  exp_t sb[$];
  exp_t cur, me;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  logic [CW-1:0] m_sc = '0, m_fc = '0;
  always #5 clk = ~clk;
  pipe_hazard_tracker #(.DEPTH(DEPTH), .REG_ADDR_WIDTH(AW), .LOAD_READY(LR), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .ValidD(ValidD), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .IsLoadD(IsLoadD), .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .FwdAE(FwdAE), .FwdBE(FwdBE), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, exp, cyc);
    end
  endtask
  // age of an in-flight instruction = cycles since it entered E
  function automatic int src(input logic [AW-1:0] r);
    int best, age;
    bit ok;
    best = 0;
    ok = 0;
    foreach (fl[i]) begin
      age = cyc - fl[i].birth;
      if (age >= 1 && age < DEPTH && fl[i].we && fl[i].rd != 0 && fl[i].rd == r && (best == 0 || age < best)) begin
        best = age;
        ok = !fl[i].ld || age >= LR;
      end
    end
    return ok ? best : 0;
  endfunction
  function automatic exp_t model();
    exp_t e;
    logic lu;
    int age;
    e.fa = '0;
    e.fb = '0;
    lu = 1'b0;
    foreach (fl[i]) begin
      age = cyc - fl[i].birth;
      if (age == 0) begin
        e.fa = FW'(src(fl[i].rs1));
        e.fb = FW'(src(fl[i].rs2));
      end
      if (age <= LR - 2 && fl[i].we && fl[i].ld && fl[i].rd != 0 && (fl[i].rd == Rs1D || fl[i].rd == Rs2D)) lu = 1'b1;
    end
    lu = lu && ValidD;
    e.sf = lu && !PCSrcE;
    e.sd = e.sf;
    e.fd = PCSrcE;
    e.fe = PCSrcE || lu;
`ifdef HAZARD_PERF_EN
    e.sc = m_sc;
    e.fc = m_fc;
`else
    e.sc = '0;
    e.fc = '0;
`endif
    return e;
  endfunction
  task automatic drive(input logic v, input logic [AW-1:0] r1, r2, rd, input logic we, ld, pc);
    ValidD = v; Rs1D = r1; Rs2D = r2; RdD = rd; RegWriteD = we; IsLoadD = ld; PCSrcE = pc;
    cur = model();
    sb.push_back(cur);
  endtask
  task automatic tick();
    ins_t n;
    @(posedge clk);
    if (reset) begin
      if (ValidD && !cur.fe) begin
        n.rd = RdD; n.rs1 = Rs1D; n.rs2 = Rs2D; n.we = RegWriteD; n.ld = IsLoadD; n.birth = cyc + 1;
        fl.push_back(n);
      end
      m_sc = m_sc + CW'(cur.sd);
      m_fc = m_fc + CW'(cur.fd);
    end
    cyc++;
    while (fl.size() > 0 && cyc - fl[0].birth >= DEPTH) void'(fl.pop_front());
    #1;
  endtask
  task automatic nops(input int n);
    repeat (n) begin
      drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask
  task automatic hold_reset(input int n);
    reset = 1'b0;
    fl.delete();
    m_sc = '0;
    m_fc = '0;
    repeat (n) begin
      drive(ValidD, Rs1D, Rs2D, RdD, RegWriteD, IsLoadD, 1'b0);
      tick();
    end
    reset = 1'b1;
  endtask
  // holds the D instruction while stalled; returns stall cycles seen on the DUT
  task automatic issue(input logic [AW-1:0] r1, r2, rd, input logic we, ld, output int stalls);
    int g = 0;
    stalls = 0;
    do begin
      drive(1'b1, r1, r2, rd, we, ld, 1'b0);
      #3;
      if (StallD) stalls++;
      tick();
      g++;
    end while (cur.sd && g < 20);
    if (g >= 20) chk("issue_bound", 32'(g), 32'(0));
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      chk("StallF", 32'(StallF), 32'(me.sf));
      chk("StallD", 32'(StallD), 32'(me.sd));
      chk("FlushD", 32'(FlushD), 32'(me.fd));
      chk("FlushE", 32'(FlushE), 32'(me.fe));
      chk("FwdAE", 32'(FwdAE), 32'(me.fa));
      chk("FwdBE", 32'(FwdBE), 32'(me.fb));
      chk("StallCnt", 32'(StallCnt), 32'(me.sc));
      chk("FlushCnt", 32'(FlushCnt), 32'(me.fc));
    end
  end
  initial begin
    int st, w;
    logic [AW-1:0] h1, h2, hd;
    logic hv, hw, hl;
    @(posedge clk);
    #1;
    hold_reset(2);
    nops(DEPTH);
    issue(0, 0, 5, 1, 0, st);
    issue(5, 5, 6, 1, 0, st);
    chk("b2b_stall", 32'(st), 32'(0));
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("b2b_FwdAE", 32'(FwdAE), 32'(1));
    chk("b2b_FwdBE", 32'(FwdBE), 32'(1));
    tick();
    nops(DEPTH);
    issue(0, 0, 5, 1, 1, st);
    issue(5, 0, 7, 1, 0, st);
    chk("lu_stall_cycles", 32'(st), 32'(2));
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("lu_FwdAE", 32'(FwdAE), 32'(3));
    chk("lu_FwdBE", 32'(FwdBE), 32'(0));
    tick();
    nops(DEPTH);
    issue(0, 0, 3, 1, 0, st);
    issue(0, 0, 3, 1, 0, st);
    issue(3, 0, 8, 1, 0, st);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("youngest_FwdAE", 32'(FwdAE), 32'(1));
    tick();
    issue(0, 0, 0, 1, 0, st);
    issue(0, 0, 0, 1, 0, st);
    issue(0, 0, 8, 1, 0, st);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("x0_FwdAE", 32'(FwdAE), 32'(0));
    tick();
    nops(DEPTH);
    issue(0, 0, 5, 1, 1, st);
    drive(1'b1, 5, 0, 7, 1'b1, 1'b0, 1'b1);
    #3;
    chk("br_lu_StallF", 32'(StallF), 32'(0));
    chk("br_lu_StallD", 32'(StallD), 32'(0));
    chk("br_lu_FlushD", 32'(FlushD), 32'(1));
    chk("br_lu_FlushE", 32'(FlushE), 32'(1));
    tick();
    nops(DEPTH);
    issue(0, 0, 5, 1, 1, st);
    reset = 1'b0;
    fl.delete();
    m_sc = '0;
    m_fc = '0;
    drive(1'b1, 5, 0, 7, 1'b1, 1'b0, 1'b0);
    #3;
    chk("rst_StallF", 32'(StallF), 32'(0));
    chk("rst_FlushE", 32'(FlushE), 32'(0));
    chk("rst_FwdAE", 32'(FwdAE), 32'(0));
    chk("rst_StallCnt", 32'(StallCnt), 32'(0));
    tick();
    reset = 1'b1;
    drive(1'b1, 5, 0, 7, 1'b1, 1'b0, 1'b0);
    #3;
    chk("post_rst_StallD", 32'(StallD), 32'(0));
    tick();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    chk("post_rst_FwdAE", 32'(FwdAE), 32'(0));
    tick();
    hv = 0; hw = 0; hl = 0; h1 = '0; h2 = '0; hd = '0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 1199) == 0) hold_reset(1 + int'($urandom_range(0, 1)));
      else begin
        if (!cur.sd) begin
          hv = $urandom_range(0, 7) != 0;
          w = ($urandom_range(0, 4) == 0) ? 31 : 3;
          h1 = AW'($urandom_range(0, w));
          h2 = AW'($urandom_range(0, w));
          hd = AW'($urandom_range(0, w));
          hw = $urandom_range(0, 3) != 0;
          hl = $urandom_range(0, 2) == 0;
        end
        drive(hv, h1, h2, hd, hw, hl, $urandom_range(0, 9) == 0);
        tick();
      end
    end
    nops(2);
    if (sb.size() != 0) chk("scoreboard_drain", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
